// File: rtl/sar_search_if.sv
// Comparator/control bundle for sar_search: the start and comparator flags go in,
// and the probe and search status come out.
interface sar_search_if #(
  parameter int W = 8
);
  localparam int SW = $clog2(W + 2);

  logic          start;
  logic          a_gt_b;
  logic          a_eq_b;
  logic          a_ls_b;
  logic [W-1:0]  probe;
  logic          busy;
  logic          done;
  logic          found;
  logic          err;
  logic [W-1:0]  result;
  logic [SW-1:0] steps;

  modport master (
    output start, a_gt_b, a_eq_b, a_ls_b,
    input  probe, busy, done, found, err, result, steps
  );

  modport slave (
    input  start, a_gt_b, a_eq_b, a_ls_b,
    output probe, busy, done, found, err, result, steps
  );
endinterface

// File: rtl/sar_search.sv
// Binary-search controller. It steps a probe against an external magnitude comparator
// until it finds the target, runs out of range, or sees flags that are not one-hot.
module sar_search #(
  parameter int W = 8
) (
  input logic         clk,
  input logic         rst_n,
  sar_search_if.slave bus
);
  localparam int SW = $clog2(W + 2);
  localparam logic [W-1:0] MAXV = '1;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  lo_q, lo_d, hi_q, hi_d;
  logic [W-1:0]  probe_q, probe_d, result_q, result_d;
  logic [SW-1:0] steps_q, steps_d;
  logic          found_q, found_d, err_q, err_d, done_q, done_d;
  logic          onehot, upd;
  logic [W:0]    sum;

  assign onehot = ({bus.a_gt_b, bus.a_eq_b, bus.a_ls_b} == 3'b100) ||
                  ({bus.a_gt_b, bus.a_eq_b, bus.a_ls_b} == 3'b010) ||
                  ({bus.a_gt_b, bus.a_eq_b, bus.a_ls_b} == 3'b001);

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    probe_d  = probe_q;
    result_d = result_q;
    steps_d  = steps_q;
    found_d  = found_q;
    err_d    = err_q;
    done_d   = 1'b0;
    upd      = 1'b0;
    sum      = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          lo_d    = '0;
          hi_d    = MAXV;
          probe_d = MAXV >> 1;
          steps_d = '0;
          found_d = 1'b0;
          err_d   = 1'b0;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        steps_d = steps_q + SW'(1);
        if (!onehot) begin
          err_d   = 1'b1;
          found_d = 1'b0;
          state_d = DONE;
        end else if (bus.a_eq_b) begin
          result_d = probe_q;
          found_d  = 1'b1;
          state_d  = DONE;
        end else if (bus.a_gt_b) begin
          if (probe_q == MAXV) begin
            found_d = 1'b0;
            state_d = DONE;
          end else begin
            lo_d = probe_q + W'(1);
            upd  = 1'b1;
          end
        end else begin
          if (probe_q == '0) begin
            found_d = 1'b0;
            state_d = DONE;
          end else begin
            hi_d = probe_q - W'(1);
            upd  = 1'b1;
          end
        end
        // The midpoint uses the freshly narrowed bounds, so the next probe is ready one edge later.
        if (upd) begin
          if (lo_d > hi_d) begin
            found_d = 1'b0;
            state_d = DONE;
          end else begin
            sum     = {1'b0, lo_d} + {1'b0, hi_d};
            probe_d = W'(sum >> 1);
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      probe_q  <= '0;
      result_q <= '0;
      steps_q  <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      probe_q  <= probe_d;
      result_q <= result_d;
      steps_q  <= steps_d;
      found_q  <= found_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign bus.probe  = probe_q;
  assign bus.busy   = (state_q == SEARCH);
  assign bus.done   = done_q;
  assign bus.found  = found_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;
  assign bus.steps  = steps_q;
endmodule
